// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch stage.
//   ifu_state_e   : fetch FSM state (request, drain stale request, blocked on full skid)
//   fetch_entry_t : one buffered instruction with its fetch address + 4
//   IFU_NOP       : instruction presented when no valid instruction is held
//   PC_STEP       : program counter increment per fetched word
//   align_word()  : forces the two low address bits to zero
package ifu_pkg;

  typedef enum logic [1:0] {
    StReq     = 2'd0,
    StDrain   = 2'd1,
    StBlocked = 2'd2
  } ifu_state_e;

  localparam logic [31:0] IFU_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: instruction memory request/response bus.
//   imem_req   : request valid (held with imem_addr until imem_ready)
//   imem_addr  : word-aligned fetch address
//   imem_ready : memory completes the request this cycle
//   imem_rdata : fetched word, valid while imem_ready is high
// Modports: master (fetch stage side), slave (memory side).
interface instruction_fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: output slot plus one skid entry between memory and IF/ID.
//   clock, reset   : clock and synchronous active-high reset
//   flush          : drop both entries (redirect)
//   push           : accept push_entry this cycle
//   push_entry     : accepted instruction and its pc + 4
//   stall          : downstream does not consume the output slot this cycle
//   out_valid      : output slot holds a real instruction
//   out_entry      : output slot contents
//   skid_full_next : skid entry will be occupied after this edge
module fetch_skid_buffer
  import ifu_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         stall,
  output logic         out_valid,
  output fetch_entry_t out_entry,
  output logic         skid_full_next
);

  logic         out_valid_q, out_valid_d;
  fetch_entry_t out_entry_q, out_entry_d;
  logic         skid_valid_q, skid_valid_d;
  fetch_entry_t skid_entry_q, skid_entry_d;
  logic         consume;

  assign consume = out_valid_q && !stall;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_entry_d  = out_entry_q;
    skid_valid_d = skid_valid_q;
    skid_entry_d = skid_entry_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_entry_d  = '0;
      skid_valid_d = 1'b0;
      skid_entry_d = '0;
    end else if (consume || !out_valid_q) begin
      // Output slot is free this edge: the older skid entry goes first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_entry_d  = skid_entry_q;
        skid_valid_d = push;
        skid_entry_d = push ? push_entry : '0;
      end else if (push) begin
        out_valid_d = 1'b1;
        out_entry_d = push_entry;
      end else begin
        out_valid_d = 1'b0;
        out_entry_d = '0;
      end
    end else if (push) begin
      // Output slot held by a stall; park the new word in the skid.
      skid_valid_d = 1'b1;
      skid_entry_d = push_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_entry_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_entry_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_entry_q  <= out_entry_d;
      skid_valid_q <= skid_valid_d;
      skid_entry_q <= skid_entry_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_entry      = out_entry_q;
  assign skid_full_next = skid_valid_d;

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: IF stage of the 5-stage pipeline. Owns the program counter,
// fetches words over the imem bus and presents them to the IF/ID registers through a
// 2-entry buffer. Handles redirects, including ones that land mid-request.
//   RESET_PC       : first fetch address after reset
//   clock, reset   : clock and synchronous active-high reset
//   stall          : presented instruction not consumed this cycle
//   redirect       : taken branch/jump, flush and refetch from redirect_pc
//   redirect_pc    : redirect target (low two bits ignored)
//   imem           : instruction memory bus (master modport)
//   if_valid       : if_* holds a real instruction
//   if_pc_4        : fetch address + 4 of the presented instruction
//   if_instruction : presented instruction, NOP when if_valid is low
// Optional feature macro IFU_PERF_COUNTERS_EN adds:
//   perf_fetched   : count of accepted, non-discarded words
//   perf_bubbles   : count of cycles with if_valid low and stall low
module instruction_fetch_stage
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  instruction_fetch_stage_if.master imem,
  output logic        if_valid,
  output logic [31:0] if_pc_4,
  output logic [31:0] if_instruction
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  ifu_state_e   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         req;
  logic [31:0]  addr;
  logic         push;
  fetch_entry_t push_entry;
  logic         out_valid;
  fetch_entry_t out_entry;
  logic         skid_full_next;

  // Requests are held through reset-free states except BLOCKED; reset drops them.
  assign req  = !reset && (state_q != StBlocked);
  // A draining request keeps its original address even after pc has moved on.
  assign addr = (state_q == StDrain) ? drain_addr_q : pc_q;

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  // Only a live REQ completion is kept; data in a redirect cycle is stale.
  assign push             = (state_q == StReq) && req && imem.imem_ready && !redirect;
  assign push_entry.instr = imem.imem_rdata;
  assign push_entry.pc_4  = pc_q + PC_STEP;

  fetch_skid_buffer u_buffer (
    .clock          (clock),
    .reset          (reset),
    .flush          (redirect),
    .push           (push),
    .push_entry     (push_entry),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_entry      (out_entry),
    .skid_full_next (skid_full_next)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    if (redirect) begin
      pc_d = align_word(redirect_pc);
      if (req && !imem.imem_ready) begin
        // Request still in flight: let it finish at its old address and drop the data.
        state_d      = StDrain;
        drain_addr_d = addr;
      end else begin
        state_d = StReq;
      end
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem.imem_ready) begin
            pc_d    = pc_q + PC_STEP;
            state_d = skid_full_next ? StBlocked : StReq;
          end
        end
        StDrain: begin
          if (imem.imem_ready) begin
            state_d = StReq;
          end
        end
        StBlocked: begin
          if (!skid_full_next) begin
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign if_valid       = out_valid;
  assign if_pc_4        = out_entry.pc_4;
  assign if_instruction = out_valid ? out_entry.instr : IFU_NOP;

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_bubbles_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (!out_valid && !stall) begin
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: self-checking bench for instruction_fetch_stage.
// Memory model answers with a word derived from the address after a configurable or
// random latency; the instruction stream is checked against the expected program order.
module tb_instruction_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc_4;
  logic [31:0] if_instruction;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_stage_if imem_bus ();

  instruction_fetch_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .if_valid       (if_valid),
    .if_pc_4        (if_pc_4),
    .if_instruction (if_instruction)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: fixed latency mem_lat, or random 1..3 per request when mem_rand is set.
  int unsigned mem_lat  = 1;
  bit          mem_rand = 1'b0;
  int unsigned wait_cnt = 0;
  int unsigned cur_lat  = 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
  endfunction

  assign imem_bus.imem_ready = imem_bus.imem_req && ((wait_cnt + 1) >= cur_lat);
  assign imem_bus.imem_rdata = imem_bus.imem_ready ? word_of(imem_bus.imem_addr)
                                                   : 32'hBAD0_BAD0;

  always @(posedge clock) begin
    if (reset || !imem_bus.imem_req || imem_bus.imem_ready) begin
      wait_cnt <= 0;
      cur_lat  <= mem_rand ? $urandom_range(1, 3) : mem_lat;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int unsigned lat);
    mem_rand    = 1'b0;
    mem_lat     = lat;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    reset       = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    mem_lat = 1;
    reset   = 1'b1;
    step();
    step();
    n_checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req got=%b exp=0", imem_bus.imem_req);
    end
    n_checks++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got=%b exp=0", if_valid);
    end
    n_checks++;
    if (if_instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_instr got=%h exp=0", if_instruction);
    end
    n_checks++;
    if (if_pc_4 !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_pc4 got=%h exp=0", if_pc_4);
    end
    n_checks++;
    if (imem_bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_addr got=%h exp=0", imem_bus.imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_addr;
      exp_addr = 32'(4 * k);
      n_checks++;
      if (imem_bus.imem_addr !== exp_addr || imem_bus.imem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL zw_addr cyc=%0d got=%h/%b exp=%h/1", k, imem_bus.imem_addr,
                 imem_bus.imem_req, exp_addr);
      end
      if (k > 0) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc_4 !== exp_addr ||
            if_instruction !== word_of(exp_addr - 32'd4)) begin
          n_fail++;
          $display("FAIL zw_out cyc=%0d got=%b/%h/%h exp=1/%h/%h", k, if_valid, if_pc_4,
                   if_instruction, exp_addr, word_of(exp_addr - 32'd4));
        end
      end else begin
        n_checks++;
        if (if_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL zw_first_valid got=%b exp=0", if_valid);
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    int got;
    do_reset(1);
    step();
    step();
    step();
    n_checks++;
    if (if_pc_4 !== 32'd12) begin
      n_fail++;
      $display("FAIL st_pre_pc4 got=%h exp=c", if_pc_4);
    end
    stall = 1'b1;
    step();
    n_checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL st_req_drop got=%b exp=0", imem_bus.imem_req);
    end
    n_checks++;
    if (if_valid !== 1'b1 || if_pc_4 !== 32'd12) begin
      n_fail++;
      $display("FAIL st_hold got=%b/%h exp=1/c", if_valid, if_pc_4);
    end
    step();
    step();
    stall = 1'b0;
    got   = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (if_valid) begin
        logic [31:0] exp_pc;
        exp_pc = 32'(8 + 4 * got);
        n_checks++;
        if (if_pc_4 !== exp_pc + 32'd4 || if_instruction !== word_of(exp_pc)) begin
          n_fail++;
          $display("FAIL st_order idx=%0d got=%h/%h exp=%h/%h", got, if_pc_4, if_instruction,
                   exp_pc + 32'd4, word_of(exp_pc));
        end
        got++;
      end
      step();
    end
    n_checks++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL st_timeout got=%0d exp=3", got);
    end
  endtask

  task automatic test_redirect_drain();
    int cyc;
    do_reset(3);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    n_checks++;
    if (imem_bus.imem_addr !== 32'h0 || imem_bus.imem_req !== 1'b1 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_stale got=%h/%b/%b exp=0/1/0", imem_bus.imem_addr,
               imem_bus.imem_req, if_valid);
    end
    step();
    n_checks++;
    if (imem_bus.imem_addr !== 32'h100 || imem_bus.imem_req !== 1'b1 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_target got=%h/%b/%b exp=100/1/0", imem_bus.imem_addr,
               imem_bus.imem_req, if_valid);
    end
    cyc = 3;
    while (!if_valid && cyc < 20) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != 6 || if_pc_4 !== 32'h104 || if_instruction !== word_of(32'h100)) begin
      n_fail++;
      $display("FAIL rd_first cyc=%0d got=%h/%h exp cyc=6 %h/%h", cyc, if_pc_4,
               if_instruction, 32'h104, word_of(32'h100));
    end
  endtask

  task automatic test_redirect_ready();
    int cyc;
    do_reset(3);
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    redirect = 1'b0;
    n_checks++;
    if (imem_bus.imem_addr !== 32'h200 || imem_bus.imem_req !== 1'b1 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_target got=%h/%b/%b exp=200/1/0", imem_bus.imem_addr,
               imem_bus.imem_req, if_valid);
    end
    cyc = 3;
    while (!if_valid && cyc < 20) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != 6 || if_pc_4 !== 32'h204 || if_instruction !== word_of(32'h200)) begin
      n_fail++;
      $display("FAIL rr_first cyc=%0d got=%h/%h exp cyc=6 %h/%h", cyc, if_pc_4,
               if_instruction, 32'h204, word_of(32'h200));
    end
  endtask

  task automatic test_reset_in_drain();
    int cyc;
    do_reset(4);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    n_checks++;
    if (imem_bus.imem_addr !== 32'h0 || imem_bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rdn_drain got=%h/%b exp=0/1", imem_bus.imem_addr, imem_bus.imem_req);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rdn_req_in_reset got=%b exp=0", imem_bus.imem_req);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem_bus.imem_addr !== 32'h0 || imem_bus.imem_req !== 1'b1 || if_valid !== 1'b0 ||
        if_instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL rdn_release got=%h/%b/%b/%h exp=0/1/0/0", imem_bus.imem_addr,
               imem_bus.imem_req, if_valid, if_instruction);
    end
    cyc = 0;
    while (!if_valid && cyc < 20) begin
      step();
      cyc++;
    end
    n_checks++;
    if (if_valid !== 1'b1 || if_pc_4 !== 32'h4 || if_instruction !== word_of(32'h0)) begin
      n_fail++;
      $display("FAIL rdn_first got=%b/%h/%h exp=1/4/%h", if_valid, if_pc_4, if_instruction,
               word_of(32'h0));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        p_req;
    logic        p_ready;
    logic [31:0] p_addr;
    int          consumed;
    do_reset(1);
    mem_rand = 1'b1;
    exp_pc   = 32'h0;
    p_req    = 1'b0;
    p_ready  = 1'b0;
    p_addr   = 32'h0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      if (p_req && !p_ready) begin
        n_checks++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== p_addr) begin
          n_fail++;
          $display("FAIL rnd_hold cyc=%0d got=%b/%h exp=1/%h", c, imem_bus.imem_req,
                   imem_bus.imem_addr, p_addr);
        end
      end
      if (!if_valid) begin
        n_checks++;
        if (if_instruction !== 32'h0) begin
          n_fail++;
          $display("FAIL rnd_nop cyc=%0d got=%h exp=0", c, if_instruction);
        end
      end
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      if (redirect) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (if_valid && !stall) begin
        n_checks++;
        if (if_pc_4 !== exp_pc + 32'd4 || if_instruction !== word_of(exp_pc)) begin
          n_fail++;
          $display("FAIL rnd_stream cyc=%0d got=%h/%h exp=%h/%h", c, if_pc_4, if_instruction,
                   exp_pc + 32'd4, word_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      p_req   = imem_bus.imem_req;
      p_ready = imem_bus.imem_ready;
      p_addr  = imem_bus.imem_addr;
      step();
    end
    stall    = 1'b0;
    redirect = 1'b0;
    mem_rand = 1'b0;
    n_checks++;
    if (consumed < 200) begin
      n_fail++;
      $display("FAIL rnd_progress got=%0d exp>=200", consumed);
    end
  endtask

`ifdef IFU_PERF_COUNTERS_EN
  task automatic test_perf();
    int vcnt;
    int bcnt;
    bit done_redir;
    do_reset(2);
    vcnt       = 0;
    bcnt       = 0;
    done_redir = 1'b0;
    for (int c = 0; c < 80; c++) begin
      redirect = 1'b0;
      if (if_valid) vcnt++;
      n_checks++;
      if (perf_fetched !== 32'(vcnt) || perf_bubbles !== 32'(bcnt)) begin
        n_fail++;
        $display("FAIL perf_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, perf_fetched,
                 perf_bubbles, vcnt, bcnt);
      end
      if (!if_valid) bcnt++;
      if (vcnt == 9) break;
      if (!done_redir && vcnt == 2 && imem_bus.imem_req && !imem_bus.imem_ready) begin
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        done_redir  = 1'b1;
      end
      step();
    end
    redirect = 1'b0;
    n_checks++;
    if (perf_fetched !== 32'd9 || !done_redir) begin
      n_fail++;
      $display("FAIL perf_total got=%0d redir=%b exp=9/1", perf_fetched, done_redir);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_drain();
    test_redirect_ready();
    test_reset_in_drain();
    test_random();
`ifdef IFU_PERF_COUNTERS_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction fetch stage of the 5-stage pipeline. It owns the program counter, issues word requests to instruction memory over a req/ready handshake, and presents `if_pc_4`/`if_instruction` to the IF/ID pipeline registers. It absorbs memory latency and downstream stalls with a 2-entry output buffer, and handles branch/jump redirects, including a redirect that lands while a request is still in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clock` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: from hazard unit; the presented instruction is not consumed this cycle.
- `redirect` input 1: taken branch/jump; flush and refetch.
- `redirect_pc` input 32: redirect target; bits [1:0] ignored (forced 0).
- `imem_req` output 1: request valid.
- `imem_addr` output 32: word-aligned fetch address.
- `imem_ready` input 1: memory completes the request; `imem_rdata` is valid this cycle.
- `imem_rdata` input 32: fetched instruction word.
- `if_valid` output 1: output slot holds a real instruction.
- `if_pc_4` output 32: fetch address + 4 of the presented instruction.
- `if_instruction` output 32: presented instruction; 32'h0 (NOP) when `if_valid`=0.

## Operation
- Request rule: once `imem_req`=1, `imem_req` and `imem_addr` stay stable until the cycle `imem_ready`=1.
- States:
  - REQ: request at `pc`.
  - DRAIN: request at a stale address. Data is discarded.
  - BLOCKED: `imem_req`=0 because the skid entry is full.
- Buffer: output slot (drives `if_*`) plus one skid entry.
  - Consume = `if_valid` && !`stall`.
  - On consume, the skid moves to the output slot if full.
  - Accepted data goes to the output slot if it is empty or being consumed, otherwise to the skid.
- REQ with `imem_ready`: capture `imem_rdata` and `pc+4`, then `pc <= pc+4` (mod 2^32).
  - Go to BLOCKED if the skid becomes full, else stay in REQ.
- BLOCKED → REQ the cycle after the skid empties.
- Redirect has highest priority, including over `stall`:
  - Clear output slot and skid.
  - `pc <= {redirect_pc[31:2],2'b00}`.
  - If a request is outstanding and `imem_ready`=0 that cycle, go to DRAIN. Otherwise go to REQ.
  - `imem_rdata` arriving in the redirect cycle is discarded.
- DRAIN with `imem_ready`: discard the data and go to REQ at `pc`.
- Redirect during DRAIN: update `pc`, stay in DRAIN.
- Reset values:
  - `pc`=`RESET_PC`, state REQ.
  - `if_valid`=0, `if_instruction`=0, `if_pc_4`=0, skid empty.
  - `imem_req` forced 0 while `reset`=1.
  - `imem_addr`=`RESET_PC`.
- Reset mid-DRAIN or mid-request: the in-flight request is abandoned. The memory side tolerates a dropped request on reset.

## Timing
- Zero-wait memory, no stall: one instruction per cycle. Data accepted at edge N appears on `if_*` in cycle N+1.
- Memory latency L cycles: throughput is 1/L, and `if_valid` is 0 in between.
- Redirect at edge N: `if_valid`=0 in cycle N+1. With no drain, `imem_addr`=target in cycle N+1.
- Stall cannot lose or duplicate instructions. At most 2 instructions are buffered.

## Configuration
- `IFU_PERF_COUNTERS_EN` defined: adds outputs `perf_fetched` (32, count of accepted non-discarded words) and `perf_bubbles` (32, count of cycles with `if_valid`=0 && !`stall`).
  - Both reset to 0 and wrap mod 2^32.
- Not defined: the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Package `ifu_pkg`: state enum (REQ, DRAIN, BLOCKED), `IFU_NOP`=32'h0, `PC_STEP`=4.
- Sub-module `fetch_skid_buffer`: output slot plus skid entry with push/consume/flush.
- The top level holds `pc`, the FSM and the memory handshake.

## Test plan
- Reset release, zero-wait memory, `RESET_PC`=0 → `imem_addr` 0,4,8 on consecutive cycles; `if_pc_4` 4,8,12 one cycle later; `if_valid`=1 continuously.
- Zero-wait memory, `stall`=1 for 3 cycles while presenting the word at addr 8 → addr 12 goes to the skid and `imem_req` drops. After release, the 8, 12, 16 words are delivered in order with no duplicates.
- 3-cycle memory, redirect to 32'h100 in the 2nd wait cycle:
  - `imem_addr` stays at the old address until ready, and that data is discarded.
  - Next request is at 0x100; `if_valid`=0 throughout.
- Redirect to 32'h203 in the same cycle as `imem_ready` → no DRAIN; `imem_addr`=0x200 next cycle; rdata discarded.
- Reset asserted during DRAIN → cycle after release: `imem_addr`=`RESET_PC`, `imem_req`=1, `if_valid`=0, `if_instruction`=0.
- With `IFU_PERF_COUNTERS_EN`, 10 fetches with 1 redirect draining 1 word → `perf_fetched`=9; `perf_bubbles` matches the count of invalid non-stall cycles.
